// File: rtl/step_cnt_gen_if.sv
// Control/status bundle between the lab top level (switches, buttons) and the
// LED step counter. The master drives the controls; the counter (slave) drives status.
interface step_cnt_gen_if #(
  parameter int CNT_W  = 33,
  parameter int STEP_W = 7,
  parameter int LED_W  = 8
);
  logic              en;
  logic              start;
  logic              load;
  logic [CNT_W-1:0]  load_val;
  logic              dir;
  logic [1:0]        mode;
  logic [STEP_W-1:0] cnt_step;
  logic [CNT_W-1:0]  cnt;
  logic [LED_W-1:0]  led;
  logic              busy;
  logic              tc;
  logic              done;

  // Level-sampled controls, no valid/ready: every input is consumed on each rising edge.
  modport master (
    output en, start, load, load_val, dir, mode, cnt_step,
    input  cnt, led, busy, tc, done
  );

  modport slave (
    input  en, start, load, load_val, dir, mode, cnt_step,
    output cnt, led, busy, tc, done
  );
endinterface

// File: rtl/step_cnt_gen.sv
// Parametrised up/down step counter for the LED bank: wrap, saturate and
// one-shot reload end-of-range modes, run control FSM, tc/done pulses.
module step_cnt_gen #(
  parameter int               CNT_W  = 33,
  parameter int               STEP_W = 7,
  parameter int               LED_W  = 8,
  parameter logic [CNT_W-1:0] INIT   = 33'h1_5555_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  step_cnt_gen_if.slave bus,
  output logic [1:0]  o_dbg_state
);
  localparam int XW = CNT_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_reload, w_reload_nxt;
  logic             r_tc, w_tc_nxt;
  logic             r_done, w_done_nxt;

  logic [XW-1:0]    w_inc;
  logic [XW-1:0]    w_cnt_ext;
  logic [XW-1:0]    w_sum;
  logic [XW-1:0]    w_all_ones;
  logic             w_carry;
  logic             w_boundary;

  // Extended arithmetic: bit CNT_W is carry (up) or borrow (down).
  assign w_inc      = XW'(bus.cnt_step) + XW'(1);
  assign w_cnt_ext  = {1'b0, r_cnt};
  assign w_sum      = bus.dir ? (w_cnt_ext - w_inc) : (w_cnt_ext + w_inc);
  assign w_all_ones = {1'b0, {CNT_W{1'b1}}};
  assign w_carry    = w_sum[CNT_W];
  assign w_boundary = bus.dir ? (w_carry || (w_sum == '0))
                              : (w_sum >= w_all_ones);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;
    w_done_nxt   = 1'b0;

    if (bus.load) begin
      w_cnt_nxt    = bus.load_val;
      w_reload_nxt = bus.load_val;
      w_state_nxt  = S_IDLE;
    end else if (bus.start && (r_state != S_RUN)) begin
      w_state_nxt = S_RUN;
    end else if ((r_state == S_RUN) && bus.en) begin
      if (!w_boundary) begin
        w_cnt_nxt = w_sum[CNT_W-1:0];
      end else begin
        case (bus.mode)
          2'b01: begin
            w_cnt_nxt   = bus.dir ? '0 : {CNT_W{1'b1}};
            w_tc_nxt    = 1'b1;
            w_state_nxt = S_DONE;
          end
          2'b10: begin
            w_cnt_nxt   = r_reload;
            w_tc_nxt    = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
          default: begin
            // Exact hit on all-ones/zero is not a terminal count in wrap mode.
            w_cnt_nxt = w_sum[CNT_W-1:0];
            w_tc_nxt  = w_carry;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= INIT;
      r_reload <= INIT;
      r_tc     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.cnt     = r_cnt;
  assign bus.led     = r_cnt[CNT_W-1 -: LED_W];
  assign bus.busy    = (r_state == S_RUN);
  assign bus.tc      = r_tc;
  assign bus.done    = r_done;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_step_cnt_gen.sv
// Bench for step_cnt_gen: directed scenarios then randomized traffic, all
// checked every cycle against an integer-arithmetic model of the counter.
module tb_step_cnt_gen;
  localparam int               CNT_W  = 33;
  localparam int               STEP_W = 7;
  localparam int               LED_W  = 8;
  localparam logic [CNT_W-1:0] INIT   = 33'h1_5555_FFFF;
  localparam longint           LIM    = (longint'(1) << CNT_W) - 1;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks;
  int         failures;

  // Model: phase 0 = idle, 1 = running, 2 = finished after saturation
  longint m_cnt;
  longint m_rel;
  int     m_phase;
  logic   m_tc;
  logic   m_done;
  logic [CNT_W-1:0] exp_q[$];

  step_cnt_gen_if #(.CNT_W(CNT_W), .STEP_W(STEP_W), .LED_W(LED_W)) bus ();

  step_cnt_gen #(.CNT_W(CNT_W), .STEP_W(STEP_W), .LED_W(LED_W), .INIT(INIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply the counter rules to the inputs about to be sampled.
  task automatic model_edge();
    longint nv;
    longint inc;
    bit     hit;
    bit     over;
    m_tc   = 1'b0;
    m_done = 1'b0;
    if (!rst) begin
      m_cnt   = longint'(INIT);
      m_rel   = longint'(INIT);
      m_phase = 0;
    end else if (bus.load) begin
      m_cnt   = longint'(bus.load_val);
      m_rel   = longint'(bus.load_val);
      m_phase = 0;
    end else if (bus.start && m_phase != 1) begin
      m_phase = 1;
    end else if (m_phase == 1 && bus.en) begin
      inc = longint'(bus.cnt_step) + 1;
      if (!bus.dir) begin
        nv   = m_cnt + inc;
        hit  = (nv >= LIM);
        over = (nv > LIM);
      end else begin
        nv   = m_cnt - inc;
        hit  = (nv <= 0);
        over = (nv < 0);
      end
      if (!hit) begin
        m_cnt = nv;
      end else if (bus.mode == 2'b01) begin
        m_cnt   = bus.dir ? 0 : LIM;
        m_tc    = 1'b1;
        m_phase = 2;
      end else if (bus.mode == 2'b10) begin
        m_cnt   = m_rel;
        m_tc    = 1'b1;
        m_done  = 1'b1;
        m_phase = 0;
      end else begin
        m_cnt = nv & LIM;
        m_tc  = over;
      end
    end
    exp_q.push_back(m_cnt[CNT_W-1:0]);
  endtask

  // Driver: one clock with the currently applied inputs, then scoreboard check.
  task automatic cyc();
    logic [CNT_W-1:0] e;
    model_edge();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("cnt", 64'(bus.cnt), 64'(e));
    chk("led", 64'(bus.led), 64'(e[CNT_W-1 -: LED_W]));
    chk("busy", 64'(bus.busy), 64'(m_phase == 1));
    chk("tc", 64'(bus.tc), 64'(m_tc));
    chk("done", 64'(bus.done), 64'(m_done));
  endtask

  task automatic idle_inputs();
    bus.en = 1'b0; bus.start = 1'b0; bus.load = 1'b0;
  endtask

  task automatic do_load(input logic [CNT_W-1:0] v);
    idle_inputs();
    bus.load = 1'b1; bus.load_val = v;
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  function automatic logic [CNT_W-1:0] pick_val();
    int k;
    k = $urandom_range(0, 3);
    case (k)
      0: pick_val = {CNT_W{1'b1}} - CNT_W'($urandom_range(0, 300));
      1: pick_val = CNT_W'($urandom_range(0, 300));
      default: pick_val = {1'($urandom_range(0, 1)), 32'($urandom)};
    endcase
  endfunction

  initial begin
    checks = 0; failures = 0;
    m_cnt = 0; m_rel = 0; m_phase = 0; m_tc = 0; m_done = 0;
    rst = 1'b0; idle_inputs();
    bus.load_val = '0; bus.dir = 1'b0; bus.mode = 2'b00; bus.cnt_step = '0;
    @(posedge clk); #1;

    // Reset with random control noise
    for (int i = 0; i < 2; i++) begin
      bus.en = 1'($urandom); bus.start = 1'($urandom); bus.load = 1'($urandom);
      bus.load_val = pick_val();
      cyc();
    end
    chk("rst_cnt", 64'(bus.cnt), 64'h1_5555_FFFF);
    chk("rst_led", 64'(bus.led), 64'hAA);
    rst = 1'b1; idle_inputs(); bus.en = 1'b1;
    cyc();
    chk("hold_no_start", 64'(bus.cnt), 64'h1_5555_FFFF);

    // Wrap up with carry out
    do_load(33'h1_FFFF_FFFE);
    bus.mode = 2'b00; bus.dir = 1'b0; bus.cnt_step = 7'd2; bus.en = 1'b1;
    do_start();
    cyc();
    chk("wrap_first", 64'(bus.cnt), 64'h1);
    chk("wrap_tc", 64'(bus.tc), 64'h1);
    cyc();
    chk("wrap_second", 64'(bus.cnt), 64'h4);

    // Saturate down
    do_load(33'd5);
    bus.mode = 2'b01; bus.dir = 1'b1; bus.cnt_step = 7'd6; bus.en = 1'b1;
    do_start();
    cyc();
    chk("sat_cnt", 64'(bus.cnt), 64'h0);
    chk("sat_busy", 64'(bus.busy), 64'h0);
    cyc(); cyc();
    do_start();
    chk("sat_restart", 64'(bus.busy), 64'h1);
    cyc();

    // One-shot up with reload
    do_load(33'h1_FFFF_FFF0);
    bus.mode = 2'b10; bus.dir = 1'b0; bus.cnt_step = 7'd7; bus.en = 1'b1;
    do_start();
    cyc();
    chk("os_first", 64'(bus.cnt), 64'h1_FFFF_FFF8);
    cyc();
    chk("os_reload", 64'(bus.cnt), 64'h1_FFFF_FFF0);
    chk("os_done", 64'(bus.done), 64'h1);

    // Priority: load beats start in RUN; reset beats load
    bus.mode = 2'b00; bus.en = 1'b1;
    do_start();
    cyc();
    bus.load = 1'b1; bus.start = 1'b1; bus.load_val = 33'h0_1234_5678;
    cyc();
    chk("prio_load", 64'(bus.cnt), 64'h0_1234_5678);
    rst = 1'b0;
    cyc();
    chk("prio_rst", 64'(bus.cnt), 64'h1_5555_FFFF);
    rst = 1'b1; idle_inputs();

    // Mid-run changes with unit step
    do_load(33'h0_8000_0000);
    bus.mode = 2'b00; bus.cnt_step = '0;
    do_start();
    for (int i = 0; i < 24; i++) begin
      bus.dir = 1'($urandom); bus.en = 1'($urandom);
      cyc();
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 99) != 0);
      bus.load     = ($urandom_range(0, 24) == 0);
      bus.load_val = pick_val();
      bus.start    = ($urandom_range(0, 5) == 0);
      bus.en       = ($urandom_range(0, 3) != 0);
      bus.dir      = 1'($urandom);
      bus.mode     = 2'($urandom_range(0, 3));
      bus.cnt_step = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 127))
                                                 : 7'($urandom_range(0, 3));
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/step_cnt_gen.md
# step_cnt_gen

Parametrised step counter driving a board LED bank. It is the general form of the fixed 33-bit/7-bit-step LED counter. It adds width, step and display parameters, up/down counting, three end-of-range modes (wrap, saturate, one-shot reload), synchronous load, an explicit start/run state machine, and terminal-count/done flags. It sits between board switches/buttons (already debounced and synchronised upstream) and the LED outputs in the lab top level.

## Interface

Parameters:
- CNT_W, 33, counter width; legal range LED_W..64
- STEP_W, 7, width of cnt_step; effective increment inc = cnt_step + 1, range 1..2^STEP_W
- LED_W, 8, number of counter MSBs shown on led
- INIT, 33'h1_5555_FFFF, reset value of cnt and of the reload register

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- en  in  1  advance enable, sampled in RUN only
- start  in  1  IDLE/DONE -> RUN request
- load  in  1  synchronous load of load_val
- load_val  in  CNT_W  load/reload value
- dir  in  1  0 = up, 1 = down
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
- cnt_step  in  STEP_W  step minus one
- cnt  out  CNT_W  counter value (registered)
- led  out  LED_W  cnt[CNT_W-1 : CNT_W-LED_W]
- busy  out  1  high while state = RUN
- tc  out  1  one-cycle terminal-count pulse
- done  out  1  one-cycle pulse on one-shot completion

## Operation

- States:
  - IDLE: holds cnt.
  - RUN: advances cnt when en = 1.
  - DONE: holds cnt after saturation.
- Priority each edge, highest first: rst=0 > load > start > advance.
- rst=0 → cnt=INIT, reload_r=INIT, state=IDLE, busy=0, tc=0, done=0. led therefore = INIT MSBs (0xAA at defaults).
- load=1, any state → cnt=load_val, reload_r=load_val, state=IDLE. No tc or done.
- start=1 in IDLE or DONE → state=RUN. No advance on that edge. start in RUN is ignored.
- Advance (RUN, en=1):
  - Arithmetic is done in CNT_W+1 bits: sum = cnt + inc (up) or cnt - inc (down).
  - Boundary is true when the up result is ≥ 2^CNT_W-1, or the down result is ≤ 0. This includes underflow, and an exact hit on all-ones or zero.
- Per-mode response when boundary is true:
  - wrap: cnt = sum mod 2^CNT_W. tc=1 only on carry/borrow out, not on an exact hit. State stays RUN.
  - saturate: cnt = all-ones (up) or 0 (down). tc=1. State becomes DONE.
  - one-shot: cnt = reload_r. tc=1, done=1. State becomes IDLE.
- When boundary is false: cnt = sum. tc=0.
- mode, dir and cnt_step are sampled on every advancing edge. Changing them mid-run is legal and takes effect on the next advance.
- en=0 in RUN holds cnt. No pulses are generated.

## Timing

- All outputs are registered. cnt, tc, done and busy update on the same edge as the advance that causes them.
- tc and done are high for exactly one cycle per event. If boundary events occur back-to-back (wrap with large inc), tc is high on each such cycle.
- start-to-first-advance latency: 1 cycle (start edge → RUN; the next edge with en advances).
- Load-to-output latency: 1 edge. Reset-to-output latency: 1 edge.
- rst=0 during RUN takes effect on the next edge regardless of en, load or start.
- busy = (state == RUN), driven from the state register.

## Test plan

- Reset: hold rst=0 for 2 cycles with random en, start and load → cnt=0x1_5555_FFFF, led=0xAA, busy=0, tc=0, done=0. After rst=1 with en=1 and no start, cnt stays unchanged.
- Wrap up: load 0x1_FFFF_FFFE, mode=00, dir=0, cnt_step=2, start, en=1 → the first advance gives cnt=0x0_0000_0001 with tc=1 for one cycle. The next advance gives 0x0_0000_0004 with tc=0.
- Saturate down: load 5, mode=01, dir=1, cnt_step=6, start, en=1 → cnt=0, tc=1, state=DONE, busy=0. Further en cycles leave cnt=0. start returns busy=1.
- One-shot up: load 0x1_FFFF_FFF0, mode=10, dir=0, cnt_step=7, start, en=1 → advances give 0x1_FFFF_FFF8, then the reload value 0x1_FFFF_FFF0 with tc=1, done=1, busy=0.
- Priority: load=1 and start=1 on the same edge while in RUN → cnt=load_val, state=IDLE, busy=0. rst=0 together with load → cnt=INIT.
- Mid-run changes: in RUN, toggle dir and set cnt_step=0 while en toggles → cnt changes by exactly ±1 on each en=1 edge only. led tracks cnt MSBs on the same edge.
